pcs_an_xmit_ctrl: RTL and testbench
===================================

PCS_AN_XMIT_CTRL -- requirements
Module: pcs_an_xmit_ctrl

Interface
REQ-001 Parameter LINK_TIMER, default 16, link-timer duration in GTX_CLK cycles (legal range 2..65535).
REQ-002 Parameter MATCH_CNT, default 3, consecutive identical /C/ words required for a match (legal range 2..7).
REQ-003 GTX_CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 mr_an_enable  input  1  1 = run auto-negotiation, 0 = force link up.
REQ-006 mr_restart_an  input  1  level; 1 forces restart of negotiation.
REQ-007 mr_adv_ability  input  16  local advertised config word (bit 14 ignored).
REQ-008 rx_config_valid  input  1  1 = rx_config_reg holds a newly received /C/ word this cycle.
REQ-009 rx_config_reg  input  16  received config word.
REQ-010 rx_idle  input  1  1 = receive process reports /I/ this cycle.
REQ-011 xmit  output  2  transmit mode: 2'b00 IDLE, 2'b01 CONFIGURATION, 2'b10 DATA; 2'b11 never driven.
REQ-012 tx_config_reg  output  16  config word for the transmit ordered-set generator.
REQ-013 mr_an_complete  output  1  negotiation finished, link usable.
REQ-014 mr_lp_adv_ability  output  16  last matched partner word.
REQ-015 an_state  output  3  current state encoding (debug).

Function
REQ-016 States and encodings: AN_ENABLE=0, AN_RESTART=1, ABILITY_DETECT=2, ACK_DETECT=3, COMPLETE_ACK=4, IDLE_DETECT=5, LINK_OK=6, AN_DISABLE_LINK_OK=7.
REQ-017 All outputs registered; outputs reflect the new state in the cycle after the transition condition is sampled.
REQ-018 Per-state outputs: AN_ENABLE/AN_RESTART: xmit=CONFIGURATION, tx_config_reg=0; ABILITY_DETECT: CONFIGURATION, mr_adv_ability with bit14=0; ACK_DETECT/COMPLETE_ACK: CONFIGURATION, mr_adv_ability with bit14=1; IDLE_DETECT: IDLE, tx_config_reg=0; LINK_OK/AN_DISABLE_LINK_OK: DATA, tx_config_reg=0.
REQ-019 mr_an_complete=1 only in LINK_OK; mr_an_complete=0 in AN_DISABLE_LINK_OK and all other states.
REQ-020 Link timer: counter cleared on entry to AN_RESTART, COMPLETE_ACK, IDLE_DETECT; link_timer_done asserts when count = LINK_TIMER-1; counter saturates there.
REQ-021 Match tracker: on each rx_config_valid, compare rx_config_reg (bit14 masked) to held word; equal -> count+1 saturating at MATCH_CNT; unequal -> hold new word, count=1; cycles with rx_config_valid=0 leave count unchanged.
REQ-022 ability_match = count >= MATCH_CNT; acknowledge_match = ability_match and last three received words have bit14=1; tracker cleared on every state transition.
REQ-023 Transitions: AN_ENABLE -> AN_RESTART (unconditional, 1 cycle) if mr_an_enable=1, else -> AN_DISABLE_LINK_OK; AN_RESTART -> ABILITY_DETECT on link_timer_done.
REQ-024 ABILITY_DETECT -> ACK_DETECT on ability_match with matched word != 0; matched word is latched into mr_lp_adv_ability.
REQ-025 ACK_DETECT -> COMPLETE_ACK on acknowledge_match with matched word (bit14 masked) = mr_lp_adv_ability; -> AN_ENABLE if matched word != mr_lp_adv_ability.
REQ-026 COMPLETE_ACK -> IDLE_DETECT on link_timer_done; IDLE_DETECT -> LINK_OK on link_timer_done and rx_idle=1 in the same cycle.
REQ-027 In ACK_DETECT, COMPLETE_ACK, IDLE_DETECT, LINK_OK: ability_match on an all-zero word -> AN_ENABLE (partner restart).
REQ-028 From any state: mr_restart_an=1 -> AN_ENABLE; mr_an_enable 1->0 -> AN_ENABLE; precedence mr_restart_an > partner restart > normal transition.
REQ-029 AN_DISABLE_LINK_OK exits only via mr_restart_an or mr_an_enable becoming 1 (-> AN_ENABLE).
REQ-030 Reset mid-negotiation discards timer, tracker and latched partner word with no extra cycles.

Reset
REQ-031 While RESET=0: an_state=AN_ENABLE, xmit=2'b01, tx_config_reg=0, mr_an_complete=0, mr_lp_adv_ability=0, timer and tracker cleared.
REQ-032 First state change occurs at the first rising GTX_CLK edge after RESET returns high.

Verification
REQ-033 Partner sends 0x01A0 (x3) then 0x41A0 (x3), then rx_idle=1 -> states 1,2,3,4,5,6; mr_lp_adv_ability=0x01A0; xmit ends at 2'b10; mr_an_complete=1.
REQ-034 Words 0x01A0,0x01A0,0x0020,0x01A0 in ABILITY_DETECT -> no transition until three consecutive 0x01A0.
REQ-035 In LINK_OK, three consecutive 0x0000 /C/ words -> AN_ENABLE, xmit=2'b01, mr_an_complete=0 the following cycle.
REQ-036 mr_an_enable=0 out of reset -> AN_DISABLE_LINK_OK after 1 cycle, xmit=2'b10, mr_an_complete=0.
REQ-037 mr_restart_an pulsed in COMPLETE_ACK together with link_timer_done -> AN_ENABLE wins; link timer restarts from 0 in AN_RESTART.
REQ-038 RESET asserted in IDLE_DETECT -> all outputs at reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/pcs_an_xmit_ctrl_if.sv
// rtl/pcs_an_xmit_ctrl_if.sv - Receive/transmit path bundle for the auto-negotiation controller
//
// Purpose: bundles the per-cycle signals exchanged between the PCS receive/transmit
// ordered-set logic and the auto-negotiation transmit controller.
//
// Signals:
//   rx_config_valid  1   a newly received /C/ word is present on rx_config_reg
//   rx_config_reg    16  received config word
//   rx_idle          1   receive process reports /I/ this cycle
//   xmit             2   transmit mode: 00 IDLE, 01 CONFIGURATION, 10 DATA
//   tx_config_reg    16  config word handed to the transmit ordered-set generator
//
// Modports:
//   master  PCS side: drives the receive indications, observes the transmit mode
//   slave   controller side: consumes the receive indications, drives the transmit mode
interface pcs_an_xmit_ctrl_if;
  logic        rx_config_valid;
  logic [15:0] rx_config_reg;
  logic        rx_idle;
  logic [1:0]  xmit;
  logic [15:0] tx_config_reg;

  modport master (
    output rx_config_valid,
    output rx_config_reg,
    output rx_idle,
    input  xmit,
    input  tx_config_reg
  );

  modport slave (
    input  rx_config_valid,
    input  rx_config_reg,
    input  rx_idle,
    output xmit,
    output tx_config_reg
  );
endinterface

// File: rtl/pcs_an_xmit_ctrl.sv
// rtl/pcs_an_xmit_ctrl.sv - 1000BASE-X style auto-negotiation transmit controller
//
// Purpose: runs the clause-37 style auto-negotiation handshake. It advertises the
// local ability word, tracks consecutive identical /C/ words from the partner,
// steps through ability / acknowledge / idle detection with a link timer, and
// selects the transmit mode (CONFIGURATION, IDLE, DATA).
//
// Parameters:
//   LINK_TIMER  link-timer duration in GTX_CLK cycles (2..65535)
//   MATCH_CNT   consecutive identical /C/ words required for a match (2..7)
//
// Ports:
//   GTX_CLK            in   sole clock, rising edge
//   RESET              in   asynchronous active-low reset
//   mr_an_enable       in   1 = negotiate, 0 = force link up
//   mr_restart_an      in   level, forces negotiation restart
//   mr_adv_ability     in   16  local advertised word (bit 14 ignored)
//   pcs                slave modport: rx_config_valid/rx_config_reg/rx_idle in,
//                      xmit/tx_config_reg out
//   mr_an_complete     out  negotiation finished, link usable
//   mr_lp_adv_ability  out  16  last matched partner word
//   an_state           out  3   current state encoding
module pcs_an_xmit_ctrl #(
  parameter int unsigned LINK_TIMER = 16,
  parameter int unsigned MATCH_CNT  = 3
) (
  input  logic              GTX_CLK,
  input  logic              RESET,
  input  logic              mr_an_enable,
  input  logic              mr_restart_an,
  input  logic [15:0]       mr_adv_ability,
  pcs_an_xmit_ctrl_if.slave pcs,
  output logic              mr_an_complete,
  output logic [15:0]       mr_lp_adv_ability,
  output logic [2:0]        an_state
);

  typedef enum logic [2:0] {
    AN_ENABLE          = 3'd0,
    AN_RESTART         = 3'd1,
    ABILITY_DETECT     = 3'd2,
    ACK_DETECT         = 3'd3,
    COMPLETE_ACK       = 3'd4,
    IDLE_DETECT        = 3'd5,
    LINK_OK            = 3'd6,
    AN_DISABLE_LINK_OK = 3'd7
  } state_e;

  localparam logic [1:0]  XMIT_IDLE   = 2'b00;
  localparam logic [1:0]  XMIT_CONFIG = 2'b01;
  localparam logic [1:0]  XMIT_DATA   = 2'b10;
  localparam logic [15:0] ACK_BIT     = 16'h4000;
  localparam logic [15:0] TIMER_LAST  = 16'(LINK_TIMER - 1);
  localparam logic [2:0]  MATCH_MAX   = 3'(MATCH_CNT);

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [15:0] match_word_q, match_word_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [2:0]  ack_hist_q, ack_hist_d;
  logic        an_enable_q, an_enable_d;
  logic [15:0] lp_q, lp_d;
  logic [1:0]  xmit_q, xmit_d;
  logic [15:0] tx_cfg_q, tx_cfg_d;
  logic        complete_q, complete_d;

  logic        link_timer_done;
  logic        ability_match;
  logic        acknowledge_match;
  logic        partner_restart;
  logic        enable_fell;
  logic        state_change;
  logic [15:0] rx_word_masked;

  always_comb begin
    link_timer_done   = (timer_q == TIMER_LAST);
    ability_match     = (match_cnt_q >= MATCH_MAX);
    // Acknowledge needs the ACK bit on the last three received words, not just
    // on the word that happens to be held for the match comparison.
    acknowledge_match = ability_match && (ack_hist_q == 3'b111);
    partner_restart   = ability_match && (match_word_q == 16'h0000);
    enable_fell       = an_enable_q && !mr_an_enable;
    rx_word_masked    = pcs.rx_config_reg & ~ACK_BIT;

    // Next-state selection; management restart overrides everything below.
    state_d = state_q;
    case (state_q)
      AN_ENABLE: begin
        state_d = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
      end
      AN_RESTART: begin
        if (link_timer_done) state_d = ABILITY_DETECT;
      end
      ABILITY_DETECT: begin
        if (ability_match && (match_word_q != 16'h0000)) state_d = ACK_DETECT;
      end
      ACK_DETECT: begin
        if (partner_restart) begin
          state_d = AN_ENABLE;
        end else if (acknowledge_match && (match_word_q == lp_q)) begin
          state_d = COMPLETE_ACK;
        end else if (ability_match && (match_word_q != lp_q)) begin
          state_d = AN_ENABLE;
        end
      end
      COMPLETE_ACK: begin
        if (partner_restart)      state_d = AN_ENABLE;
        else if (link_timer_done) state_d = IDLE_DETECT;
      end
      IDLE_DETECT: begin
        if (partner_restart)                         state_d = AN_ENABLE;
        else if (link_timer_done && pcs.rx_idle)     state_d = LINK_OK;
      end
      LINK_OK: begin
        if (partner_restart) state_d = AN_ENABLE;
      end
      AN_DISABLE_LINK_OK: begin
        if (mr_an_enable) state_d = AN_ENABLE;
      end
      default: state_d = AN_ENABLE;
    endcase
    if (mr_restart_an || enable_fell) state_d = AN_ENABLE;

    state_change = (state_d != state_q);

    // Link timer: restarted on entry to the timed states, saturates at done.
    timer_d = timer_q;
    if (state_change &&
        ((state_d == AN_RESTART) || (state_d == COMPLETE_ACK) || (state_d == IDLE_DETECT))) begin
      timer_d = 16'h0000;
    end else if (!link_timer_done) begin
      timer_d = timer_q + 16'd1;
    end

    // Match tracker: a word arriving on a transition edge is discarded with the
    // rest of the tracker so each state starts counting from scratch.
    match_word_d = match_word_q;
    match_cnt_d  = match_cnt_q;
    ack_hist_d   = ack_hist_q;
    if (state_change) begin
      match_word_d = 16'h0000;
      match_cnt_d  = 3'd0;
      ack_hist_d   = 3'b000;
    end else if (pcs.rx_config_valid) begin
      ack_hist_d = {ack_hist_q[1:0], pcs.rx_config_reg[14]};
      if (rx_word_masked == match_word_q) begin
        if (match_cnt_q < MATCH_MAX) match_cnt_d = match_cnt_q + 3'd1;
      end else begin
        match_word_d = rx_word_masked;
        match_cnt_d  = 3'd1;
      end
    end

    lp_d = lp_q;
    if ((state_q == ABILITY_DETECT) && (state_d == ACK_DETECT)) lp_d = match_word_q;

    an_enable_d = mr_an_enable;

    // Outputs are decoded from the next state so they change on the same edge
    // as the state register.
    xmit_d   = XMIT_DATA;
    tx_cfg_d = 16'h0000;
    case (state_d)
      AN_ENABLE, AN_RESTART: begin
        xmit_d = XMIT_CONFIG;
      end
      ABILITY_DETECT: begin
        xmit_d   = XMIT_CONFIG;
        tx_cfg_d = mr_adv_ability & ~ACK_BIT;
      end
      ACK_DETECT, COMPLETE_ACK: begin
        xmit_d   = XMIT_CONFIG;
        tx_cfg_d = mr_adv_ability | ACK_BIT;
      end
      IDLE_DETECT: begin
        xmit_d = XMIT_IDLE;
      end
      default: begin
        xmit_d = XMIT_DATA;
      end
    endcase
    complete_d = (state_d == LINK_OK);
  end

  always_ff @(posedge GTX_CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= AN_ENABLE;
      timer_q      <= 16'h0000;
      match_word_q <= 16'h0000;
      match_cnt_q  <= 3'd0;
      ack_hist_q   <= 3'b000;
      an_enable_q  <= 1'b0;
      lp_q         <= 16'h0000;
      xmit_q       <= XMIT_CONFIG;
      tx_cfg_q     <= 16'h0000;
      complete_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      match_word_q <= match_word_d;
      match_cnt_q  <= match_cnt_d;
      ack_hist_q   <= ack_hist_d;
      an_enable_q  <= an_enable_d;
      lp_q         <= lp_d;
      xmit_q       <= xmit_d;
      tx_cfg_q     <= tx_cfg_d;
      complete_q   <= complete_d;
    end
  end

  assign an_state          = state_q;
  assign pcs.xmit          = xmit_q;
  assign pcs.tx_config_reg = tx_cfg_q;
  assign mr_an_complete    = complete_q;
  assign mr_lp_adv_ability = lp_q;

endmodule

// File: tb/tb_pcs_an_xmit_ctrl.sv
// tb/tb_pcs_an_xmit_ctrl.sv - Scoreboard bench for the auto-negotiation transmit controller
module tb_pcs_an_xmit_ctrl;

  localparam logic [15:0] ADV     = 16'h41E0;
  localparam logic [15:0] ADV_AB  = 16'h01E0;
  localparam logic [15:0] ADV_ACK = 16'h41E0;
  localparam logic [15:0] LP      = 16'h01A0;

  logic        GTX_CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        mr_an_enable = 1'b1;
  logic        mr_restart_an = 1'b0;
  logic [15:0] mr_adv_ability = ADV;
  logic        mr_an_complete;
  logic [15:0] mr_lp_adv_ability;
  logic [2:0]  an_state;

  pcs_an_xmit_ctrl_if pcs_if ();

  pcs_an_xmit_ctrl #(.LINK_TIMER(16), .MATCH_CNT(3)) dut (
    .GTX_CLK           (GTX_CLK),
    .RESET             (RESET),
    .mr_an_enable      (mr_an_enable),
    .mr_restart_an     (mr_restart_an),
    .mr_adv_ability    (mr_adv_ability),
    .pcs               (pcs_if),
    .mr_an_complete    (mr_an_complete),
    .mr_lp_adv_ability (mr_lp_adv_ability),
    .an_state          (an_state)
  );

  always #5 GTX_CLK = ~GTX_CLK;

  int unsigned cyc = 0;
  always @(posedge GTX_CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  st;
    logic [1:0]  xm;
    logic [15:0] tx;
    logic        cp;
    logic [15:0] lp;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [2:0] prev_state = 3'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cyc %0d", name, act, req, cyc);
    end
  endtask

  task automatic push(input int unsigned c, input logic [2:0] st, input logic [1:0] xm,
                      input logic [15:0] tx, input logic cp, input logic [15:0] lp);
    exp_t r;
    r.cyc = c; r.st = st; r.xm = xm; r.tx = tx; r.cp = cp; r.lp = lp;
    exp_q.push_back(r);
  endtask

  // Monitor: every state change the DUT presents is matched against the next
  // expected record, including the cycle on which it had to happen.
  always @(negedge GTX_CLK) begin
    if (mon_en && (an_state !== prev_state)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_transition actual_state=%0d required=none at cyc %0d", an_state, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("state", 32'(an_state), 32'(e.st));
        chk("cycle", cyc, e.cyc);
        chk("xmit", 32'(pcs_if.xmit), 32'(e.xm));
        chk("tx_config_reg", 32'(pcs_if.tx_config_reg), 32'(e.tx));
        chk("mr_an_complete", 32'(mr_an_complete), 32'(e.cp));
        chk("mr_lp_adv_ability", 32'(mr_lp_adv_ability), 32'(e.lp));
      end
    end
    prev_state = an_state;
  end

  task automatic tick();
    @(posedge GTX_CLK);
    #1;
  endtask

  task automatic tick_until(input int unsigned c);
    while (cyc < c) tick();
  endtask

  task automatic send(input logic [15:0] w);
    pcs_if.rx_config_valid = 1'b1;
    pcs_if.rx_config_reg   = w;
    tick();
  endtask

  task automatic rx_off();
    pcs_if.rx_config_valid = 1'b0;
    pcs_if.rx_config_reg   = 16'h0000;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_an_state"}, 32'(an_state), 32'd0);
    chk({tag, "_xmit"}, 32'(pcs_if.xmit), 32'h1);
    chk({tag, "_tx_config_reg"}, 32'(pcs_if.tx_config_reg), 32'h0);
    chk({tag, "_mr_an_complete"}, 32'(mr_an_complete), 32'h0);
    chk({tag, "_mr_lp_adv_ability"}, 32'(mr_lp_adv_ability), 32'h0);
  endtask

  int unsigned r0, ea, eb, ec, rd;

  initial begin
    pcs_if.rx_config_valid = 1'b0;
    pcs_if.rx_config_reg   = 16'h0000;
    pcs_if.rx_idle         = 1'b0;

    repeat (3) tick();
    chk_reset_outputs("reset");
    mon_en = 1'b1;

    // Full negotiation with a good partner.
    r0 = cyc;
    push(r0 + 1, 3'd1, 2'b01, 16'h0000, 1'b0, 16'h0000);
    push(r0 + 17, 3'd2, 2'b01, ADV_AB, 1'b0, 16'h0000);
    RESET = 1'b1;
    ea = r0 + 17;
    tick_until(ea);
    repeat (3) send(16'h01A0);
    rx_off();
    push(ea + 4, 3'd3, 2'b01, ADV_ACK, 1'b0, LP);
    tick();
    repeat (3) send(16'h41A0);
    rx_off();
    pcs_if.rx_idle = 1'b1;
    push(ea + 8, 3'd4, 2'b01, ADV_ACK, 1'b0, LP);
    push(ea + 24, 3'd5, 2'b00, 16'h0000, 1'b0, LP);
    push(ea + 40, 3'd6, 2'b10, 16'h0000, 1'b1, LP);
    tick_until(ea + 40);

    // Partner restart from LINK_OK with zero /C/ words.
    push(ea + 44, 3'd0, 2'b01, 16'h0000, 1'b0, LP);
    push(ea + 45, 3'd1, 2'b01, 16'h0000, 1'b0, LP);
    push(ea + 61, 3'd2, 2'b01, ADV_AB, 1'b0, LP);
    repeat (3) send(16'h0000);
    rx_off();
    pcs_if.rx_idle = 1'b0;
    eb = ea + 61;
    tick_until(eb);

    // Interrupted run of matches, then ack needs bit14 on three words.
    send(16'h01A0); send(16'h01A0); send(16'h0020);
    send(16'h01A0); send(16'h01A0); send(16'h01A0);
    rx_off();
    push(eb + 7, 3'd3, 2'b01, ADV_ACK, 1'b0, LP);
    tick();
    repeat (3) send(16'h01A0);
    repeat (3) send(16'h41A0);
    rx_off();
    push(eb + 14, 3'd4, 2'b01, ADV_ACK, 1'b0, LP);

    // Restart coincides with link_timer_done in COMPLETE_ACK.
    tick_until(eb + 29);
    mr_restart_an = 1'b1;
    push(eb + 30, 3'd0, 2'b01, 16'h0000, 1'b0, LP);
    push(eb + 31, 3'd1, 2'b01, 16'h0000, 1'b0, LP);
    push(eb + 47, 3'd2, 2'b01, ADV_AB, 1'b0, LP);
    tick();
    mr_restart_an = 1'b0;
    ec = eb + 47;
    tick_until(ec);

    // Reach IDLE_DETECT with no /I/, then assert reset between edges.
    repeat (3) send(16'h01A0);
    rx_off();
    push(ec + 4, 3'd3, 2'b01, ADV_ACK, 1'b0, LP);
    tick();
    repeat (3) send(16'h41A0);
    rx_off();
    push(ec + 8, 3'd4, 2'b01, ADV_ACK, 1'b0, LP);
    push(ec + 24, 3'd5, 2'b00, 16'h0000, 1'b0, LP);
    tick_until(ec + 45);
    push(ec + 45, 3'd0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    RESET = 1'b0;
    #1;
    chk_reset_outputs("async_reset");

    // Negotiation disabled out of reset, then enable toggling and restart.
    mr_an_enable = 1'b0;
    repeat (3) tick();
    rd = cyc;
    push(rd + 1, 3'd7, 2'b10, 16'h0000, 1'b0, 16'h0000);
    RESET = 1'b1;
    tick_until(rd + 3);
    mr_an_enable = 1'b1;
    push(rd + 4, 3'd0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    push(rd + 5, 3'd1, 2'b01, 16'h0000, 1'b0, 16'h0000);
    tick_until(rd + 7);
    mr_an_enable = 1'b0;
    push(rd + 8, 3'd0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    push(rd + 9, 3'd7, 2'b10, 16'h0000, 1'b0, 16'h0000);
    tick_until(rd + 11);
    mr_restart_an = 1'b1;
    push(rd + 12, 3'd0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    push(rd + 13, 3'd7, 2'b10, 16'h0000, 1'b0, 16'h0000);
    tick();
    mr_restart_an = 1'b0;
    repeat (6) tick();

    chk("expected_transitions_left", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
